// File: rtl/alu_md_unit_pkg.sv
// alu_md_unit_pkg: operation encodings, MIPS funct/opcode values and the control decode
package alu_md_unit_pkg;

  typedef enum logic [4:0] {
    ALU_OP_ADD, ALU_OP_SUB, ALU_OP_SLL, ALU_OP_SRL, ALU_OP_SRA,
    ALU_OP_AND, ALU_OP_OR, ALU_OP_XOR, ALU_OP_NOR, ALU_OP_SLT,
    ALU_OP_MULT, ALU_OP_MULTU, ALU_OP_DIV, ALU_OP_DIVU,
    ALU_OP_MFHI, ALU_OP_MFLO, ALU_OP_NONE
  } alu_op_e;

  localparam logic [5:0] FUNCT_SLL   = 6'h00;
  localparam logic [5:0] FUNCT_SRL   = 6'h02;
  localparam logic [5:0] FUNCT_SRA   = 6'h03;
  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1a;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1b;
  localparam logic [5:0] FUNCT_ADD   = 6'h20;
  localparam logic [5:0] FUNCT_SUB   = 6'h22;
  localparam logic [5:0] FUNCT_AND   = 6'h24;
  localparam logic [5:0] FUNCT_OR    = 6'h25;
  localparam logic [5:0] FUNCT_XOR   = 6'h26;
  localparam logic [5:0] FUNCT_NOR   = 6'h27;
  localparam logic [5:0] FUNCT_SLT   = 6'h2a;

  localparam logic [5:0] OPC_ADDI = 6'h08;
  localparam logic [5:0] OPC_SLTI = 6'h0a;
  localparam logic [5:0] OPC_ANDI = 6'h0c;
  localparam logic [5:0] OPC_ORI  = 6'h0d;
  localparam logic [5:0] OPC_XORI = 6'h0e;

  function automatic alu_op_e alu_decode(input logic [1:0] alu_class, input logic [5:0] funct,
                                         input logic [5:0] op_code);
    alu_op_e op;
    op = ALU_OP_NONE;
    case (alu_class)
      2'b00: op = ALU_OP_ADD;
      2'b01: op = ALU_OP_SUB;
      2'b10:
        case (funct)
          FUNCT_ADD:   op = ALU_OP_ADD;
          FUNCT_SUB:   op = ALU_OP_SUB;
          FUNCT_SLL:   op = ALU_OP_SLL;
          FUNCT_SRL:   op = ALU_OP_SRL;
          FUNCT_SRA:   op = ALU_OP_SRA;
          FUNCT_AND:   op = ALU_OP_AND;
          FUNCT_OR:    op = ALU_OP_OR;
          FUNCT_XOR:   op = ALU_OP_XOR;
          FUNCT_NOR:   op = ALU_OP_NOR;
          FUNCT_SLT:   op = ALU_OP_SLT;
          FUNCT_MULT:  op = ALU_OP_MULT;
          FUNCT_MULTU: op = ALU_OP_MULTU;
          FUNCT_DIV:   op = ALU_OP_DIV;
          FUNCT_DIVU:  op = ALU_OP_DIVU;
          FUNCT_MFHI:  op = ALU_OP_MFHI;
          FUNCT_MFLO:  op = ALU_OP_MFLO;
          default:     op = ALU_OP_NONE;
        endcase
      default:
        case (op_code)
          OPC_ADDI: op = ALU_OP_ADD;
          OPC_SLTI: op = ALU_OP_SLT;
          OPC_ANDI: op = ALU_OP_AND;
          OPC_ORI:  op = ALU_OP_OR;
          OPC_XORI: op = ALU_OP_XOR;
          default:  op = ALU_OP_NONE;
        endcase
    endcase
    return op;
  endfunction

  function automatic logic is_iterative(input alu_op_e op);
    return op inside {ALU_OP_MULT, ALU_OP_MULTU, ALU_OP_DIV, ALU_OP_DIVU};
  endfunction

endpackage

// File: rtl/alu_md_unit_iter_muldiv.sv
// iter_muldiv: shared shift-add multiplier / restoring divider, one step per cycle on magnitudes
module iter_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             start,
  input  logic             is_div,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] hi_res,
  output logic [WIDTH-1:0] lo_res
);
  localparam int CW = $clog2(WIDTH);
  logic [WIDTH-1:0] hi_acc, lo_acc, b_r, nh, nl;
  logic [WIDTH:0] sum, rs, diff;
  logic [2*WIDTH-1:0] prod;
  logic [CW-1:0] cnt;
  logic busy, div_r, neg_q, neg_r, dz;
  // hi_acc is the partial product (mult) or partial remainder (div); lo_acc shifts multiplier/quotient
  assign sum = {1'b0, hi_acc} + (lo_acc[0] ? {1'b0, b_r} : '0);
  assign rs = {hi_acc, lo_acc[WIDTH-1]};
  assign diff = rs - {1'b0, b_r};
  assign nh = div_r ? (diff[WIDTH] ? rs[WIDTH-1:0] : diff[WIDTH-1:0]) : sum[WIDTH:1];
  assign nl = div_r ? {lo_acc[WIDTH-2:0], ~diff[WIDTH]} : {sum[0], lo_acc[WIDTH-1:1]};
  assign prod = neg_q ? -{nh, nl} : {nh, nl};
  assign done = busy && cnt == CW'(WIDTH - 1);
  // results are sign-corrected from the final step's values, ready in the done cycle
  assign hi_res = div_r ? (neg_r ? -nh : nh) : prod[2*WIDTH-1:WIDTH];
  assign lo_res = div_r ? (dz ? '1 : neg_q ? -nl : nl) : prod[WIDTH-1:0];
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      hi_acc <= '0;
      lo_acc <= '0;
      b_r <= '0;
      cnt <= '0;
      busy <= 1'b0;
      div_r <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dz <= 1'b0;
    end else if (start) begin
      hi_acc <= '0;
      lo_acc <= (is_signed && a[WIDTH-1]) ? -a : a;
      b_r <= (is_signed && b[WIDTH-1]) ? -b : b;
      cnt <= '0;
      busy <= 1'b1;
      div_r <= is_div;
      neg_q <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
      neg_r <= is_signed && a[WIDTH-1];
      dz <= b == '0;
    end else if (busy) begin
      hi_acc <= nh;
      lo_acc <= nl;
      cnt <= cnt + 1'b1;
      busy <= !done;
    end
  end
endmodule

// File: rtl/alu_md_unit.sv
// alu_md_unit: MIPS-style ALU with single-cycle ops plus iterative MULT/DIV into HI/LO
module alu_md_unit
  import alu_md_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       ALUOp,
  input  logic [5:0]       funct,
  input  logic [5:0]       op_code,
  input  logic [4:0]       shamt,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;
  state_e state, state_nx;
  alu_op_e op;
  logic accept, iter, op_div, op_signed, md_done;
  logic [WIDTH-1:0] alu_res, md_hi, md_lo;
  logic [31:0] sh;
  assign op = alu_decode(ALUOp, funct, op_code);
  assign in_ready = state == IDLE;
  assign accept = in_valid && in_ready;
  assign iter = is_iterative(op);
  assign op_div = op inside {ALU_OP_DIV, ALU_OP_DIVU};
  assign op_signed = op inside {ALU_OP_MULT, ALU_OP_DIV};
  assign sh = {27'b0, shamt} % 32'(WIDTH);
  assign zero = out_valid && result == '0;
  always_comb begin
    alu_res = '0;
    case (op)
      ALU_OP_ADD:  alu_res = x + y;
      ALU_OP_SUB:  alu_res = x - y;
      ALU_OP_SLL:  alu_res = x << sh;
      ALU_OP_SRL:  alu_res = x >> sh;
      ALU_OP_SRA:  alu_res = $signed(x) >>> sh;
      ALU_OP_AND:  alu_res = x & y;
      ALU_OP_OR:   alu_res = x | y;
      ALU_OP_XOR:  alu_res = x ^ y;
      ALU_OP_NOR:  alu_res = ~(x | y);
      ALU_OP_SLT:  alu_res = WIDTH'($signed(x) < $signed(y));
      ALU_OP_MFHI: alu_res = hi;
      ALU_OP_MFLO: alu_res = lo;
      default:     alu_res = '0;
    endcase
  end
  iter_muldiv #(.WIDTH(WIDTH)) u_md (
    .clk(clk),
    .rstb(rstb),
    .start(accept && iter),
    .is_div(op_div),
    .is_signed(op_signed),
    .a(x),
    .b(y),
    .done(md_done),
    .hi_res(md_hi),
    .lo_res(md_lo)
  );
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     state_nx = (accept && iter) ? (op_div ? DIV : MUL) : IDLE;
      MUL, DIV: state_nx = md_done ? DONE : state;
      default:  state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state <= IDLE;
      out_valid <= 1'b0;
      result <= '0;
      hi <= '0;
      lo <= '0;
    end else begin
      state <= state_nx;
      out_valid <= 1'b0;
      if (accept && !iter) begin
        result <= alu_res;
        out_valid <= 1'b1;
      end
      if (md_done) begin
        hi <= md_hi;
        lo <= md_lo;
        result <= md_lo;
        out_valid <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_alu_md_unit.sv
// tb_alu_md_unit: randomized scoreboard bench against a plain-arithmetic MIPS ALU/HI-LO model
module tb_alu_md_unit;
  localparam int W = 32;
  logic clk = 1'b0, rstb = 1'b0;
  always #5 clk = ~clk;

  logic in_valid, in_ready, out_valid, zero;
  logic [1:0] aop;
  logic [5:0] funct, op_code;
  logic [4:0] shamt;
  logic [W-1:0] x, y, result, hi, lo;

  logic in_valid8, in_ready8, out_valid8, zero8;
  logic [7:0] x8, y8, result8, hi8, lo8;

  alu_md_unit #(.WIDTH(W)) dut (
    .clk(clk), .rstb(rstb), .in_valid(in_valid), .in_ready(in_ready), .ALUOp(aop),
    .funct(funct), .op_code(op_code), .shamt(shamt), .x(x), .y(y), .out_valid(out_valid),
    .result(result), .zero(zero), .hi(hi), .lo(lo)
  );

  alu_md_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rstb(rstb), .in_valid(in_valid8), .in_ready(in_ready8), .ALUOp(2'b10),
    .funct(6'h1b), .op_code(6'h00), .shamt(5'd0), .x(x8), .y(y8), .out_valid(out_valid8),
    .result(result8), .zero(zero8), .hi(hi8), .lo(lo8)
  );

  typedef struct {
    logic [31:0] r, h, l;
    int c;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  int checks = 0, errors = 0, cyc = 0;
  logic [31:0] m_hi = '0, m_lo = '0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference semantics straight from the instruction set; updates model HI/LO
  task automatic model(input logic [1:0] a_op, input logic [5:0] fn, input logic [5:0] oc,
                       input logic [4:0] sa, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output bit it);
    longint q, rm;
    logic [63:0] p;
    r = '0;
    it = 0;
    if (a_op == 2'b00) r = a + b;
    else if (a_op == 2'b01) r = a - b;
    else if (a_op == 2'b11) begin
      case (oc)
        6'h08: r = a + b;
        6'h0a: r = {31'b0, $signed(a) < $signed(b)};
        6'h0c: r = a & b;
        6'h0d: r = a | b;
        6'h0e: r = a ^ b;
        default: r = '0;
      endcase
    end else begin
      case (fn)
        6'h20: r = a + b;
        6'h22: r = a - b;
        6'h00: r = a << sa;
        6'h02: r = a >> sa;
        6'h03: r = $signed(a) >>> sa;
        6'h24: r = a & b;
        6'h25: r = a | b;
        6'h26: r = a ^ b;
        6'h27: r = ~(a | b);
        6'h2a: r = {31'b0, $signed(a) < $signed(b)};
        6'h10: r = m_hi;
        6'h12: r = m_lo;
        6'h18, 6'h19: begin
          it = 1;
          p = (fn == 6'h18) ? 64'(longint'($signed(a)) * longint'($signed(b)))
                            : {32'b0, a} * {32'b0, b};
          m_hi = p[63:32];
          m_lo = p[31:0];
          r = m_lo;
        end
        6'h1a, 6'h1b: begin
          it = 1;
          if (b == 0) begin
            m_lo = '1;
            m_hi = a;
          end else if (fn == 6'h1a) begin
            q = longint'($signed(a)) / longint'($signed(b));
            rm = longint'($signed(a)) % longint'($signed(b));
            m_lo = q[31:0];
            m_hi = rm[31:0];
          end else begin
            m_lo = a / b;
            m_hi = a % b;
          end
          r = m_lo;
        end
        default: r = '0;
      endcase
    end
  endtask

  task automatic issue(input logic [1:0] a_op, input logic [5:0] fn, input logic [5:0] oc,
                       input logic [4:0] sa, input logic [31:0] a, input logic [31:0] b,
                       input bit push);
    int n = 0;
    exp_t e;
    bit it;
    logic [31:0] r;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 0, 1);
    aop = a_op; funct = fn; op_code = oc; shamt = sa; x = a; y = b; in_valid = 1'b1;
    if (push) begin
      model(a_op, fn, oc, sa, a, b, r, it);
      e.r = r; e.h = m_hi; e.l = m_lo; e.c = cyc + 1 + (it ? W : 0);
      sb.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0;
    aop = 2'($urandom); funct = 6'($urandom); op_code = 6'($urandom);
    shamt = 5'($urandom); x = $urandom; y = $urandom;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) chk("drain_timeout", 64'(sb.size()), 0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 7)
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(0, 9));
      default: return $urandom;
    endcase
  endfunction

  always @(negedge clk) begin
    if (rstb && out_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out_valid: result %0h with no request pending", result);
      end else begin
        mon_e = sb.pop_front();
        chk("result", 64'(result), 64'(mon_e.r));
        chk("zero", 64'(zero), 64'(mon_e.r == 0));
        chk("hi", 64'(hi), 64'(mon_e.h));
        chk("lo", 64'(lo), 64'(mon_e.l));
        chk("latency", 64'(cyc), 64'(mon_e.c));
      end
    end
  end

  initial begin
    logic [5:0] fns[17] = '{6'h20, 6'h22, 6'h00, 6'h02, 6'h03, 6'h24, 6'h25, 6'h26, 6'h27,
                            6'h2a, 6'h18, 6'h19, 6'h1a, 6'h1b, 6'h10, 6'h12, 6'h3f};
    logic [5:0] ocs[6] = '{6'h08, 6'h0a, 6'h0c, 6'h0d, 6'h0e, 6'h3f};
    int n;
    in_valid = 0; in_valid8 = 0; aop = 0; funct = 0; op_code = 0; shamt = 0;
    x = 0; y = 0; x8 = 0; y8 = 0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_result", 64'(result), 0);
    chk("rst_hi", 64'(hi), 0);
    chk("rst_lo", 64'(lo), 0);
    rstb = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 1);

    // 8-bit instance: DIVU 200/7
    x8 = 8'd200; y8 = 8'd7; in_valid8 = 1'b1;
    @(negedge clk);
    in_valid8 = 1'b0;
    n = 1;
    while (!out_valid8 && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("w8_latency", 64'(n), 9);
    chk("w8_lo", 64'(lo8), 28);
    chk("w8_hi", 64'(hi8), 4);
    chk("w8_result", 64'(result8), 28);

    issue(2'b10, 6'h20, 0, 0, 32'hFFFF_FFFF, 32'h1, 1);
    issue(2'b10, 6'h18, 0, 0, 32'hFFFF_FFFD, 32'd7, 1);
    chk("mul_in_ready_early", 64'(in_ready), 0);
    repeat (W - 1) @(negedge clk);
    chk("mul_in_ready_late", 64'(in_ready), 0);
    issue(2'b10, 6'h10, 0, 0, 0, 0, 1);
    issue(2'b10, 6'h1a, 0, 0, 32'hFFFF_FFF9, 32'd2, 1);
    issue(2'b10, 6'h1b, 0, 0, 32'd5, 32'd0, 1);
    issue(2'b10, 6'h1a, 0, 0, 32'hFFFF_FFF7, 32'd0, 1);
    issue(2'b10, 6'h1a, 0, 0, 32'h8000_0000, 32'hFFFF_FFFF, 1);
    issue(2'b11, 0, 6'h0a, 0, 32'hFFFF_FFFF, 32'h0, 1);
    issue(2'b10, 6'h03, 0, 5'd4, 32'h8000_0000, 32'h0, 1);
    issue(2'b10, 6'h12, 0, 0, 0, 0, 1);
    issue(2'b10, 6'h00, 0, 5'd31, 32'h3, 0, 1);

    for (int i = 0; i < 300; i++) begin
      issue(2'($urandom), fns[$urandom % 17], ocs[$urandom % 6], 5'($urandom), pick(), pick(), 1);
      if ($urandom % 4 == 0) @(negedge clk);
    end
    drain();

    // reset in the middle of a MULTU: no result and HI/LO cleared
    issue(2'b10, 6'h19, 0, 0, 32'hFFFF_FFFF, 32'd2, 0);
    repeat (8) @(negedge clk);
    rstb = 1'b0;
    #1;
    chk("abort_out_valid", 64'(out_valid), 0);
    chk("abort_hi", 64'(hi), 0);
    chk("abort_lo", 64'(lo), 0);
    repeat (2) @(negedge clk);
    rstb = 1'b1;
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    chk("abort_in_ready", 64'(in_ready), 1);
    repeat (40) @(negedge clk);
    chk("abort_hi_after", 64'(hi), 0);
    chk("abort_lo_after", 64'(lo), 0);
    issue(2'b11, 0, 6'h08, 0, 32'd4, 32'd5, 1);
    issue(2'b10, 6'h12, 0, 0, 0, 0, 1);
    drain();
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_md_unit.md
ALU_MD_UNIT -- requirements
Module: alu_md_unit

Interface
REQ-001 Parameter WIDTH, default 32; datapath width in bits, even, minimum 8.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rstb  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  operation request.
REQ-005 in_ready  output  1  unit can accept a request this cycle.
REQ-006 ALUOp  input  2  main-control class: 00 add, 01 sub, 10 R-type (funct), 11 I-type (op_code).
REQ-007 funct  input  6  R-type function field, MIPS encoding.
REQ-008 op_code  input  6  instruction opcode, MIPS encoding.
REQ-009 shamt  input  5  shift amount for SLL/SRL/SRA.
REQ-010 x, y  input  WIDTH each  operands (rs, rt/immediate).
REQ-011 out_valid  output  1  one-cycle pulse; result valid.
REQ-012 result  output  WIDTH  registered result.
REQ-013 zero  output  1  result == 0, qualified by out_valid.
REQ-014 hi, lo  output  WIDTH each  architectural HI/LO registers.

Function
REQ-015 Request accepted when in_valid && in_ready; inputs sampled only at acceptance, ignored otherwise.
REQ-016 Decode: ALUOp 00 ADD; 01 SUB; 10 by funct {ADD,SUB,SLL,SRL,SRA,AND,OR,XOR,NOR,SLT,MULT,MULTU,DIV,DIVU,MFHI,MFLO}; 11 by op_code {ADDI,SLTI,ANDI,ORI,XORI}; anything else -> result 0, out_valid still pulses.
REQ-017 States: IDLE, MUL, DIV, DONE; in_ready = 1 only in IDLE.
REQ-018 Single-cycle ops (incl. MFHI/MFLO): result registered on acceptance edge, out_valid high the following cycle, state stays IDLE; back-to-back accepts every cycle.
REQ-019 MULT/MULTU: IDLE->MUL, one shift-add step per cycle for WIDTH cycles, then DONE; product {hi,lo} written entering DONE; result = low half; out_valid pulses in DONE; DONE->IDLE next cycle.
REQ-020 DIV/DIVU: IDLE->DIV, restoring division, one quotient bit per cycle for WIDTH cycles, then DONE; lo = quotient, hi = remainder, result = quotient.
REQ-021 Latency: mult/div accept to out_valid = WIDTH+1 cycles; in_ready low from accept cycle+1 through DONE.
REQ-022 Signed MULT/DIV operate on magnitudes, sign-corrected in final cycle; quotient truncates toward zero; remainder takes dividend sign.
REQ-023 Divide by zero: full WIDTH cycles; lo = all ones, hi = x; no other flag.
REQ-024 Most-negative / -1 signed DIV: lo = most-negative value, hi = 0 (wrap, no trap).
REQ-025 ADD/SUB wrap modulo 2^WIDTH, no overflow output; SLT/SLTI signed compare, result 1 or 0 zero-extended.
REQ-026 Shifts use shamt mod WIDTH; SRA replicates x[WIDTH-1].
REQ-027 hi/lo change only when entering DONE; MFHI in the cycle after a mult/div completes returns new value.
REQ-028 out_valid never high in two consecutive cycles for the same request; result held until next out_valid.

Reset
REQ-029 rstb low: state IDLE, out_valid 0, result 0, hi 0, lo 0, iteration counter 0, in_ready 1 after release.
REQ-030 Reset mid-MUL/DIV aborts; no hi/lo write, no out_valid for the aborted op.

Structure
REQ-031 ALU op encodings extended in alu_defines.v (ALU_OP_MULT, MULTU, DIV, DIVU, MFHI, MFLO); FUNCT_MULT/MULTU/DIV/DIVU/MFHI/MFLO added to mips_funct_defines.v; state encodings local.
REQ-032 One sub-module, iter_muldiv, holds the iterative multiplier/divider datapath and counter; decode, single-cycle ops, FSM and hi/lo stay in alu_md_unit.

Verification
REQ-033 WIDTH=32, ALUOp=10 ADD x=0xFFFFFFFF y=1 -> next cycle out_valid=1, result=0, zero=1.
REQ-034 MULT x=-3 y=7 -> out_valid exactly 33 cycles after accept, hi=0xFFFFFFFF, lo=0xFFFFFFEB; in_ready low meanwhile.
REQ-035 DIV x=-7 y=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU x=5 y=0 -> lo=0xFFFFFFFF, hi=5.
REQ-036 rstb low at cycle 10 of a MULTU 0xFFFFFFFF*2 -> hi=lo=0, no out_valid, in_ready=1 after release; following ADDI 4+5 -> result 9.
REQ-037 Back-to-back SLTI x=-1 y=0, SRA x=0x80000000 shamt=4, MFLO every cycle -> results 1, 0xF8000000, current lo on consecutive cycles.
REQ-038 WIDTH=8 DIVU 200/7 -> lo=28, hi=4 after 9 cycles.
